// File: rtl/game_ctrl_if.sv
// game_ctrl_if: key/tick inputs and registered game state outputs of game_ctrl.
// master = key source / page renderers, slave = game_ctrl.
interface game_ctrl_if;
  logic        tick;
  logic [4:0]  keys;
  logic [1:0]  page;
  logic [2:0]  total_number;
  logic [39:0] status;
  logic [3:0]  cur_cell;
  logic [3:0]  sel_cell;
  logic        selecting;
  logic        cur_player;
  logic [1:0]  game_end;
  logic [3:0]  predict;

  modport master (
    output tick, keys,
    input  page, total_number, status, cur_cell, sel_cell,
           selecting, cur_player, game_end, predict
  );

  modport slave (
    input  tick, keys,
    output page, total_number, status, cur_cell, sel_cell,
           selecting, cur_player, game_end, predict
  );
endinterface

// File: rtl/game_ctrl.sv
// game_ctrl: page navigation, configuration, cursor, two-step move selection,
// move application and end-of-game detection for the finger-arithmetic game.
// Optional feature macro: GAME_CTRL_DRAW_EN (two consecutive zero-adds -> draw).
module game_ctrl #(
  parameter int MAX_HANDS = 5,
  parameter int MIN_HANDS = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  game_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    PG_MAIN   = 2'd0,
    PG_HELP   = 2'd1,
    PG_CONFIG = 2'd2,
    PG_GAME   = 2'd3
  } page_e;

  localparam logic [2:0]  MIN_N    = 3'(MIN_HANDS);
  localparam logic [2:0]  MAX_N    = 3'(MAX_HANDS);
  localparam logic [39:0] ALL_ONES = {10{4'h1}};

  page_e       page_q, page_d;
  logic [2:0]  total_q, total_d;
  logic [39:0] status_q, status_d;
  logic [3:0]  cur_q, cur_d;
  logic [3:0]  sel_q, sel_d;
  logic        selecting_q, selecting_d;
  logic        player_q, player_d;
  logic [1:0]  end_q, end_d;
  logic [4:0]  prev_q, prev_d;
`ifdef GAME_CTRL_DRAW_EN
  logic [1:0]  hist_q, hist_d;
`endif

  logic [4:0]  press, act;
  logic        cur_row, sel_row;
  logic [3:0]  col, base, last_col;
  logic [3:0]  own_idx, add_idx;
  logic [3:0]  own_val, add_val, new_val;

  function automatic logic [3:0] cell_of(input logic [39:0] s, input logic [3:0] idx);
    return s[{idx, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] add_mod10(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 5'd10) s = s - 5'd10;
    return s[3:0];
  endfunction

  // True when every active cell (column < n) of the given row holds 0.
  function automatic logic row_zero(input logic [39:0] s, input logic row, input logic [2:0] n);
    logic z;
    int   b;
    z = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b = (row ? 20 : 0) + 4 * i;
      if (3'(i) < n && s[b +: 4] != 4'd0) z = 1'b0;
    end
    return z;
  endfunction

  // State register: every piece of game state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      page_q      <= PG_MAIN;
      total_q     <= MIN_N;
      status_q    <= ALL_ONES;
      cur_q       <= 4'd0;
      sel_q       <= 4'd0;
      selecting_q <= 1'b0;
      player_q    <= 1'b0;
      end_q       <= 2'd0;
      prev_q      <= 5'd0;
`ifdef GAME_CTRL_DRAW_EN
      hist_q      <= 2'd0;
`endif
    end else begin
      page_q      <= page_d;
      total_q     <= total_d;
      status_q    <= status_d;
      cur_q       <= cur_d;
      sel_q       <= sel_d;
      selecting_q <= selecting_d;
      player_q    <= player_d;
      end_q       <= end_d;
      prev_q      <= prev_d;
`ifdef GAME_CTRL_DRAW_EN
      hist_q      <= hist_d;
`endif
    end
  end

  // Next state: the single highest-priority new press acts on a tick.
  always_comb begin
    page_d      = page_q;
    total_d     = total_q;
    status_d    = status_q;
    cur_d       = cur_q;
    sel_d       = sel_q;
    selecting_d = selecting_q;
    player_d    = player_q;
    end_d       = end_q;
    prev_d      = prev_q;
`ifdef GAME_CTRL_DRAW_EN
    hist_d      = hist_q;
`endif

    press = bus.keys & ~prev_q;
    if      (press[0]) act = 5'b00001;
    else if (press[1]) act = 5'b00010;
    else if (press[2]) act = 5'b00100;
    else if (press[3]) act = 5'b01000;
    else if (press[4]) act = 5'b10000;
    else               act = 5'b00000;

    cur_row  = (cur_q >= 4'd5);
    sel_row  = (sel_q >= 4'd5);
    base     = cur_row ? 4'd5 : 4'd0;
    col      = cur_q - base;
    last_col = {1'b0, total_q} - 4'd1;
    // The cell lying in the mover's row is the one that receives the sum.
    own_idx  = (cur_row == player_q) ? cur_q : sel_q;
    add_idx  = (cur_row == player_q) ? sel_q : cur_q;
    own_val  = cell_of(status_q, own_idx);
    add_val  = cell_of(status_q, add_idx);
    new_val  = add_mod10(own_val, add_val);

    if (bus.tick) begin
      prev_d = bus.keys;
      case (page_q)
        PG_MAIN: begin
          if (act[0])      page_d = PG_CONFIG;
          else if (act[3]) page_d = PG_HELP;
        end
        PG_HELP: begin
          if (act[3]) page_d = PG_MAIN;
        end
        PG_CONFIG: begin
          if (act[0]) begin
            page_d      = PG_GAME;
            status_d    = ALL_ONES;
            selecting_d = 1'b0;
            player_d    = 1'b0;
            end_d       = 2'd0;
            cur_d       = 4'd0;
            sel_d       = 4'd0;
`ifdef GAME_CTRL_DRAW_EN
            hist_d      = 2'd0;
`endif
          end else if (act[1]) begin
            if (total_q > MIN_N) total_d = total_q - 3'd1;
          end else if (act[2]) begin
            if (total_q < MAX_N) total_d = total_q + 3'd1;
          end else if (act[3]) begin
            page_d = PG_MAIN;
          end
        end
        PG_GAME: begin
          if (act[3] && end_q != 2'd0) begin
            page_d = PG_MAIN;
          end else if (act[0] || act[3]) begin
            cur_d = cur_row ? cur_q - 4'd5 : cur_q + 4'd5;
          end else if (act[1]) begin
            cur_d = base + ((col == 4'd0) ? last_col : col - 4'd1);
          end else if (act[2]) begin
            cur_d = base + ((col == last_col) ? 4'd0 : col + 4'd1);
          end else if (act[4] && end_q == 2'd0) begin
            if (!selecting_q) begin
              sel_d       = cur_q;
              selecting_d = 1'b1;
            end else begin
              selecting_d = 1'b0;
              // Same-row pair or an empty own cell cancels the selection.
              if (cur_row != sel_row && own_val != 4'd0) begin
                status_d[{own_idx, 2'b00} +: 4] = new_val;
                player_d = ~player_q;
`ifdef GAME_CTRL_DRAW_EN
                hist_d = {hist_q[0], (add_val == 4'd0)};
`endif
                if (row_zero(status_d, 1'b0, total_q))      end_d = 2'd1;
                else if (row_zero(status_d, 1'b1, total_q)) end_d = 2'd2;
`ifdef GAME_CTRL_DRAW_EN
                else if (hist_d == 2'b11)                   end_d = 2'd3;
`endif
              end
            end
          end
        end
        default: page_d = PG_MAIN;
      endcase
    end
  end

  // Outputs: registered state straight out, predict combinational.
  always_comb begin
    bus.page         = page_q;
    bus.total_number = total_q;
    bus.status       = status_q;
    bus.cur_cell     = cur_q;
    bus.sel_cell     = sel_q;
    bus.selecting    = selecting_q;
    bus.cur_player   = player_q;
    bus.game_end     = end_q;
    bus.predict      = add_mod10(cell_of(status_q, cur_q), cell_of(status_q, sel_q));
  end

endmodule
